random_access_memory_param: RTL and testbench

//  Parametrised simple dual-port register-file RAM: one write port, one read port, separate addresses.

---
 rtl/random_access_memory_param.sv | 125 ++++++++++++
 tb/tb_random_access_memory_param.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/random_access_memory_param.sv
// random_access_memory_param
//   Simple dual-port register-file RAM with one write port and one read port.
//   After reset, a clear sequencer zeroes every word before accesses are accepted.
//   All state changes on the falling edge of clock.
//
// Ports
//   clock       single clock, falling-edge active
//   reset       synchronous active-high reset, sampled on the falling edge
//   write       write request (datain -> mem[addr_w])
//   datain      write data
//   addr_w      write address
//   read        read request (mem[addr_r] -> dataout, 1-edge latency)
//   addr_r      read address
//   dataout     registered read data, holds between valid reads
//   read_valid  one-cycle pulse: dataout was updated on this edge
//   addr_err    one-cycle pulse: an accepted request used an address >= DEPTH
//   busy        high while the clear sequencer runs
//
// Build option
//   RAM_BYPASS_EN  when defined, a read and write to the same address in the
//                  same cycle return datain (write-first). When undefined, the
//                  read returns the old contents.

module random_access_memory_param #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 6,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write,
  input  logic [DATA_W-1:0] datain,
  input  logic [ADDR_W-1:0] addr_w,
  input  logic              read,
  input  logic [ADDR_W-1:0] addr_r,
  output logic [DATA_W-1:0] dataout,
  output logic              read_valid,
  output logic              addr_err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so that DEPTH == 2**ADDR_W can be represented.
  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              w_ok, r_ok;
  logic              wr_req, rd_req, wr_hit, rd_hit, clr_en;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] rd_data;

  assign w_ok   = {1'b0, addr_w} < DEPTH_L;
  assign r_ok   = {1'b0, addr_r} < DEPTH_L;
  assign wr_req = (state == ST_READY) && !reset && write;
  assign rd_req = (state == ST_READY) && !reset && read;
  assign wr_hit = wr_req && w_ok;
  assign rd_hit = rd_req && r_ok;
  assign clr_en = (state == ST_CLEAR) && !reset;

  // The clear sequencer and the user write share the single write port;
  // they are never active in the same state.
  assign mem_we = clr_en || wr_hit;
  assign mem_wa = clr_en ? ptr : addr_w[IDX_W-1:0];
  assign mem_wd = clr_en ? '0 : datain;

  // Truncated indices are only used when the range check has passed.
`ifdef RAM_BYPASS_EN
  assign rd_data = (wr_hit && (addr_w == addr_r)) ? datain : mem[addr_r[IDX_W-1:0]];
`else
  assign rd_data = mem[addr_r[IDX_W-1:0]];
`endif

  always_ff @(negedge clock) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      state      <= ST_CLEAR;
      ptr        <= '0;
      dataout    <= '0;
      read_valid <= 1'b0;
      addr_err   <= 1'b0;
      busy       <= 1'b1;
    end else begin
      read_valid <= 1'b0;
      addr_err   <= 1'b0;
      case (state)
        ST_CLEAR: begin
          if (ptr == LAST) begin
            state <= ST_READY;
            busy  <= 1'b0;
            ptr   <= '0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        ST_READY: begin
          read_valid <= rd_hit;
          if (rd_hit) begin
            dataout <= rd_data;
          end
          // Both ports out of range in one cycle still yields a single pulse.
          addr_err <= (wr_req && !w_ok) || (rd_req && !r_ok);
        end
        default: begin
          state <= ST_CLEAR;
          ptr   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_random_access_memory_param.sv
module tb_random_access_memory_param;

  localparam int DATA_W = 10;
  localparam int DEPTH  = 6;
  localparam int ADDR_W = 4;

  logic              clock;
  logic              reset;
  logic              write;
  logic [DATA_W-1:0] datain;
  logic [ADDR_W-1:0] addr_w;
  logic              read;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] dataout;
  logic              read_valid;
  logic              addr_err;
  logic              busy;

  random_access_memory_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clock(clock), .reset(reset), .write(write), .datain(datain),
    .addr_w(addr_w), .read(read), .addr_r(addr_r), .dataout(dataout),
    .read_valid(read_valid), .addr_err(addr_err), .busy(busy)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              rv;
    logic              ae;
    logic              bz;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: word array, remaining clear edges, output data register.
  logic [DATA_W-1:0] mm [DEPTH];
  int                busy_left = DEPTH;
  logic [DATA_W-1:0] m_dout    = '0;

  // Apply one cycle of stimulus (inputs change on the rising edge, the DUT
  // samples on the next falling edge) and queue the expected outputs.
  task automatic step(input logic r, input logic w, input logic [DATA_W-1:0] d,
                      input logic [ADDR_W-1:0] aw, input logic rd,
                      input logic [ADDR_W-1:0] ar);
    exp_t e;
    @(posedge clock);
    reset = r; write = w; datain = d; addr_w = aw; read = rd; addr_r = ar;
    e.rv = 1'b0;
    e.ae = 1'b0;
    if (r) begin
      busy_left = DEPTH;
      m_dout    = '0;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
      end
    end else begin
      e.ae = (w && int'(aw) >= DEPTH) || (rd && int'(ar) >= DEPTH);
      if (rd && int'(ar) < DEPTH) begin
        e.rv = 1'b1;
`ifdef RAM_BYPASS_EN
        m_dout = (w && aw == ar) ? d : mm[int'(ar)];
`else
        m_dout = mm[int'(ar)];
`endif
      end
      if (w && int'(aw) < DEPTH) mm[int'(aw)] = d;
    end
    e.d  = m_dout;
    e.bz = (busy_left != 0);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0);
  endtask

  task automatic rd_all();
    for (int i = 0; i < DEPTH; i++) step(0, 0, '0, '0, 1, ADDR_W'(i));
  endtask

  // Monitor: compares every presented output cycle against the queued expectation.
  always @(negedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks += 4;
      if (busy !== e.bz) begin
        failures++;
        $display("FAIL busy t=%0t actual=%b required=%b", $time, busy, e.bz);
      end
      if (read_valid !== e.rv) begin
        failures++;
        $display("FAIL read_valid t=%0t actual=%b required=%b", $time, read_valid, e.rv);
      end
      if (addr_err !== e.ae) begin
        failures++;
        $display("FAIL addr_err t=%0t actual=%b required=%b", $time, addr_err, e.ae);
      end
      if (dataout !== e.d) begin
        failures++;
        $display("FAIL dataout t=%0t actual=%h required=%h", $time, dataout, e.d);
      end
    end
  end

  initial begin
    reset = 1'b1; write = 1'b0; datain = '0; addr_w = '0; read = 1'b0; addr_r = '0;

    // 1: reset, clear sequence, all words read back as 0
    step(1, 0, '0, '0, 0, '0);
    idle(DEPTH);
    rd_all();
    idle(1);

    // 2: write then read, then hold
    step(0, 1, 10'h2A5, 4'd3, 0, '0);
    step(0, 0, '0, '0, 1, 4'd3);
    idle(2);

    // 3: same-address read and write in one cycle
    step(0, 1, 10'h001, 4'd2, 0, '0);
    step(0, 1, 10'h3FF, 4'd2, 1, 4'd2);
    step(0, 0, '0, '0, 1, 4'd2);

    // 4: out-of-range accesses, single pulse, nothing altered
    step(0, 1, 10'h155, 4'd6, 1, 4'd9);
    idle(1);
    step(0, 1, 10'h0AA, 4'd15, 0, '0);
    step(0, 0, '0, '0, 1, 4'd6);
    step(0, 1, 10'h111, 4'd4, 1, 4'd7);
    rd_all();

    // 5: accesses during busy are ignored; reset mid-clear restarts it
    step(1, 0, '0, '0, 0, '0);
    step(0, 1, 10'h3C3, 4'd1, 1, 4'd1);
    step(0, 1, 10'h3C3, 4'd9, 1, 4'd12);
    step(0, 1, 10'h2C2, 4'd0, 0, '0);
    step(1, 0, '0, '0, 0, '0);
    idle(DEPTH);
    rd_all();

    // 6: back-to-back reads
    step(0, 1, 10'h123, 4'd0, 0, '0);
    step(0, 1, 10'h2BC, 4'd1, 0, '0);
    step(0, 1, 10'h35A, 4'd5, 0, '0);
    step(0, 0, '0, '0, 1, 4'd0);
    step(0, 0, '0, '0, 1, 4'd1);
    step(0, 0, '0, '0, 1, 4'd5);
    idle(1);

    // Randomized traffic, including out-of-range addresses and occasional resets
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
           DATA_W'($urandom), ADDR_W'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1, ADDR_W'($urandom_range(0, 7)));
    end
    // Same-address collisions at random
    for (int i = 0; i < 100; i++) begin
      logic [ADDR_W-1:0] a;
      a = ADDR_W'($urandom_range(0, DEPTH - 1));
      step(0, 1, DATA_W'($urandom), a, 1, a);
    end
    idle(2);

    @(negedge clock);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
